// File: rtl/seg_mux_bcd_if.sv
// Bus between the game/score logic and the 7-segment display driver.
// Handshake: the master holds number stable and raises load; the driver
// captures number on a clock edge where load=1 and busy=0, raises busy on
// that edge, and keeps busy high until the converted value is committed to
// the display. A load seen while busy=1 is ignored, not queued.
`timescale 1ns/1ps
interface seg_mux_bcd_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14
);
  logic [BIN_WIDTH-1:0]  number;
  logic                  load;
  logic                  busy;
  logic                  overflow;
  logic                  blank_lz;
  logic                  blink_en;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic [6:0]            seg;
  logic                  dp;
  logic [NUM_DIGITS-1:0] an;
  // Converter state for debug and checker binding (0=IDLE, 1=SHIFT, 2=COMMIT)
  logic [1:0]            conv_state;

  modport master (
    output number, load, blank_lz, blink_en, dp_mask,
    input  busy, overflow, seg, dp, an, conv_state
  );

  modport slave (
    input  number, load, blank_lz, blink_en, dp_mask,
    output busy, overflow, seg, dp, an, conv_state
  );
endinterface

// File: rtl/seg_mux_bcd.sv
// N-digit multiplexed common-anode 7-segment driver. A binary value is
// converted to BCD by a sequential double-dabble engine, committed to a
// display register in one step, and scanned one digit per clk_500Hz cycle
// with leading-zero blanking, decimal points, blinking and overflow dashes.
`timescale 1ns/1ps
module seg_mux_bcd #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_WIDTH  = 14,
  parameter int BLINK_DIV  = 50
) (
  input  logic         clk_500Hz,
  input  logic         rst,
  seg_mux_bcd_if.slave bus
);

  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int CNT_W   = $clog2(BIN_WIDTH + 1);
  localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Largest value that fits in NUM_DIGITS decimal digits
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MAX_VAL = pow10(NUM_DIGITS) - 1;

  // Segment pattern {g,f,e,d,c,b,a}, active low; non-decimal nibbles blank
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] bin;
  logic [BCD_W-1:0]     bcd;
  logic [CNT_W-1:0]     iter;
  logic                 pend_ovf;
  logic [BCD_W-1:0]     disp;
  logic                 ovf;
  logic                 busy_r;

  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_next;
  logic [BIN_WIDTH-1:0] bin_next;

  // One double-dabble step: add 3 to every nibble >= 5, then shift left
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    {bcd_next, bin_next} = {bcd_adj, bin} << 1;
  end

  // Converter FSM; the display register only changes in COMMIT so the scan
  // never sees a partially converted value
  always_ff @(posedge clk_500Hz or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bin      <= '0;
      bcd      <= '0;
      iter     <= '0;
      pend_ovf <= 1'b0;
      disp     <= '0;
      ovf      <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) begin
            bin      <= bus.number;
            bcd      <= '0;
            iter     <= CNT_W'(BIN_WIDTH);
            pend_ovf <= (64'(bus.number) > MAX_VAL);
            busy_r   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd  <= bcd_next;
          bin  <= bin_next;
          iter <= iter - 1'b1;
          if (iter == CNT_W'(1)) state <= COMMIT;
        end
        COMMIT: begin
          disp   <= bcd;
          ovf    <= pend_ovf;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Blink timer: counts only while enabled, phase toggles at each wrap
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase_on;

  // Blink half-period counter and on/off phase
  always_ff @(posedge clk_500Hz or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (!bus.blink_en) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase_on  <= ~phase_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // upper_zero[k] is set when nibbles k..NUM_DIGITS-1 of the display are all zero
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  zero_acc;

  // Leading-zero detection from the most significant digit downwards
  always_comb begin
    zero_acc   = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc      = zero_acc & (disp[4*i +: 4] == 4'd0);
      upper_zero[i] = zero_acc;
    end
  end

  logic [DIG_W-1:0]      dig_cnt;
  logic [3:0]            cur_nib;
  logic                  cur_zero_up;
  logic                  cur_dp;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  // Select the current digit's nibble, blanking state and decimal point
  always_comb begin
    cur_nib     = 4'd0;
    cur_zero_up = 1'b0;
    cur_dp      = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (DIG_W'(i) == dig_cnt) begin
        cur_nib     = disp[4*i +: 4];
        cur_zero_up = upper_zero[i];
        cur_dp      = bus.dp_mask[i];
      end
    end
  end

  // Next segment and anode pattern; overflow dashes override blanking
  always_comb begin
    if (ovf) begin
      seg_next = 7'b0111111;
    end else if (bus.blank_lz && (dig_cnt != '0) && cur_zero_up) begin
      seg_next = 7'b1111111;
    end else begin
      seg_next = decode(cur_nib);
    end
    if (phase_on) an_next = ~(NUM_DIGITS'(1) << dig_cnt);
    else          an_next = '1;
  end

  logic [6:0]            seg_r;
  logic                  dp_r;
  logic [NUM_DIGITS-1:0] an_r;

  // Digit scan counter and registered display outputs
  always_ff @(posedge clk_500Hz or posedge rst) begin
    if (rst) begin
      dig_cnt <= '0;
      seg_r   <= 7'b1111111;
      dp_r    <= 1'b1;
      an_r    <= '1;
    end else begin
      dig_cnt <= (dig_cnt == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_cnt + 1'b1;
      seg_r   <= seg_next;
      dp_r    <= ~cur_dp;
      an_r    <= an_next;
    end
  end

  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.an         = an_r;
  assign bus.busy       = busy_r;
  assign bus.overflow   = ovf;
  assign bus.conv_state = state;

endmodule
